// File: rtl/prf_pkg.sv
// Shared types and constants for the multi-port physical register file.
// Optional feature macro used by the file set: PRF_BYPASS_EN.
package prf_pkg;

  // Sweep controller states: clearing the array, then normal operation.
  typedef enum logic {PRF_INIT, PRF_RUN} prf_state_t;

  // Physical register 0 is the architectural zero register.
  localparam int PRF_ZERO_ADDR = 0;

  // Number of physical entries for a given address width.
  function automatic int prf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/prf_init_sweep.sv
// Post-reset clearing sweep for the physical register file.
// Walks entries 1..DEPTH-1 once, one per cycle, then raises init_done.
// Entry 0 is never swept because it is hardwired in the register file.
module prf_init_sweep
  import prf_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              arst_n,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              init_done
);

  localparam int                DEPTH      = prf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(PRF_ZERO_ADDR + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  prf_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;

  // Next-state logic: advance the sweep pointer until the last entry is cleared.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      PRF_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d     = PRF_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      PRF_RUN: begin
        state_d = PRF_RUN;
      end
      default: begin
        state_d = PRF_INIT;
      end
    endcase
  end

  // State, sweep pointer and done flag; reset restarts the sweep at entry 1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= PRF_INIT;
      cnt_q       <= FIRST_ADDR;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign sweep_we   = (state_q == PRF_INIT);
  assign sweep_addr = cnt_q;
  assign init_done  = init_done_q;

endmodule

// File: rtl/prf_multiport.sv
// Multi-port physical register file with per-entry ready (scoreboard) bits.
// NUM_RD combinational read ports, NUM_WR write ports (highest index wins on
// an address collision), alloc/flush control of the ready bits, and a
// post-reset clearing sweep. Entry 0 reads as zero and always ready in RUN.
// Optional feature macro: PRF_BYPASS_EN (same-cycle write-to-read forwarding).
module prf_multiport
  import prf_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     arst_n,
  output logic                     init_done,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush
);

  localparam int                DEPTH     = prf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(PRF_ZERO_ADDR);

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  logic [DATA_W-1:0] wr_data_a [NUM_WR];
  logic [ADDR_W-1:0] wr_addr_a [NUM_WR];
  logic [DATA_W-1:0] data_arr  [DEPTH];
  logic [DEPTH-1:0]  ready_vec;

  prf_init_sweep #(
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk        (clk),
    .arst_n     (arst_n),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .init_done  (init_done)
  );

  genvar gi;

  // Unpack the write ports once so every entry can scan them by index.
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
      assign wr_addr_a[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
      assign wr_data_a[gi] = wr_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // One storage slot per entry; entry 0 is a constant, never stored.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == PRF_ZERO_ADDR) begin : g_zero
        assign data_arr[gi]  = '0;
        assign ready_vec[gi] = 1'b1;
      end else begin : g_reg
        localparam logic [ADDR_W-1:0] ENTRY_ADDR = ADDR_W'(gi);

        logic [DATA_W-1:0] data_q, data_d;
        logic              ready_q, ready_d;
        logic              wr_hit;

        // Entry update: sweep clear in INIT; in RUN, last matching write port
        // supplies data and ready follows flush > alloc > write.
        always_comb begin
          data_d  = data_q;
          ready_d = ready_q;
          wr_hit  = 1'b0;
          if (sweep_we) begin
            if (sweep_addr == ENTRY_ADDR) begin
              data_d  = '0;
              ready_d = 1'b1;
            end
          end else begin
            for (int p = 0; p < NUM_WR; p++) begin
              if (wr_en[p] && (wr_addr_a[p] == ENTRY_ADDR)) begin
                data_d = wr_data_a[p];
                wr_hit = 1'b1;
              end
            end
            if (flush) begin
              ready_d = 1'b1;
            end else if (alloc_en && (alloc_addr == ENTRY_ADDR)) begin
              ready_d = 1'b0;
            end else if (wr_hit) begin
              ready_d = 1'b1;
            end
          end
        end

        // Data storage carries no reset; the sweep provides known contents.
        always_ff @(posedge clk) begin
          data_q <= data_d;
        end

        // Ready bit clears on reset so nothing looks ready before the sweep.
        always_ff @(posedge clk or negedge arst_n) begin
          if (!arst_n) begin
            ready_q <= 1'b0;
          end else begin
            ready_q <= ready_d;
          end
        end

        assign data_arr[gi]  = data_q;
        assign ready_vec[gi] = ready_q;
      end
    end
  endgenerate

  // Read ports: zero-latency lookup, silent until the sweep completes.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr_p;
      logic [DATA_W-1:0] rd_data_p;
      logic              rd_ready_p;

      assign rd_addr_p = rd_addr[gi*ADDR_W +: ADDR_W];

      // Select stored entry, zero register, or (optionally) forwarded write data.
      always_comb begin
        rd_data_p  = '0;
        rd_ready_p = 1'b0;
        if (init_done) begin
          if (rd_addr_p == ZERO_ADDR) begin
            rd_data_p  = '0;
            rd_ready_p = 1'b1;
          end else begin
            rd_data_p  = data_arr[rd_addr_p];
            rd_ready_p = ready_vec[rd_addr_p];
`ifdef PRF_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++) begin
              if (wr_en[p] && (wr_addr_a[p] == rd_addr_p)) begin
                rd_data_p  = wr_data_a[p];
                rd_ready_p = 1'b1;
              end
            end
`endif
          end
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = rd_data_p;
      assign rd_ready[gi]                 = rd_ready_p;
    end
  endgenerate

endmodule

// File: doc/prf_multiport.md
Name: prf_multiport

Overview:
- Parametrised physical register file for the renamed out-of-order core.
- Generalises the 2R/1W file to NUM_RD read ports and NUM_WR write ports, with per-entry ready (scoreboard) bits and a post-reset clearing sweep.
- Sits between rename/issue, which read operands and ready bits and allocate destinations, and the writeback ports.
- Entry 0 is hardwired zero and always ready.

Parameters:
- ADDR_W, 6, physical register address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, data width per entry.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- init_done  out  1  high once the clearing sweep has completed.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_ready  out  NUM_RD  ready bit of each addressed entry.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- alloc_en  in  1  mark alloc_addr busy (new producer allocated).
- alloc_addr  in  ADDR_W  entry to mark busy.
- flush  in  1  mark all entries ready (pipeline flush).

Behaviour:
- Reset is asynchronous: arst_n low forces state INIT, sweep counter = 1, init_done = 0, all ready bits = 0.
- The data array has no reset.
- FSM states are INIT and RUN.
  - INIT: each cycle writes 0 to entry cnt, sets ready[cnt] = 1 and increments cnt.
  - When cnt == DEPTH-1 is written, the FSM moves to RUN.
  - The sweep takes DEPTH-1 cycles. init_done goes to 1 on the same edge that enters RUN.
  - In INIT, wr_en, alloc_en and flush are ignored. rd_data = 0 and rd_ready = 0 for every port, including address 0.
- RUN reads are combinational, 0-cycle latency.
  - Address 0 returns data 0 and ready 1.
  - Otherwise the port returns the stored entry and its ready bit.
- RUN writes take effect at posedge.
  - Each port with wr_en and a nonzero address writes its data and sets the entry's ready bit.
  - A write to address 0 is discarded.
  - Two ports writing the same address in one cycle: the highest port index wins.
- Ready-bit priority per entry at posedge: flush (all ready = 1) > alloc_en (entry busy, ready = 0) > write (ready = 1).
  - alloc and write to the same address in the same cycle leaves the entry busy. The data is still written.
  - alloc to address 0 is ignored.
- flush does not modify data.
- Asserting arst_n low mid-sweep or mid-run restarts the sweep from entry 1.
- No state stays in RUN after reset; no other FSM transitions exist.

Optional Feature:
- PRF_BYPASS_EN defined:
  - In RUN, a read whose nonzero address matches a same-cycle write (wr_en) returns that wr_data. The highest matching write port wins.
  - rd_ready is forced to 1 for that read.
  - Effective read-after-write latency is 0.
- Not defined:
  - Reads return stored contents only. Write data and ready become visible the cycle after the write edge.

Decomposition:
- Package prf_pkg holds:
  - typedef enum logic {PRF_INIT, PRF_RUN} prf_state_t;
  - parameterised helper constants PRF_ZERO_ADDR = '0;
  - the DEPTH calculation as a localparam function.
- One sub-module, prf_init_sweep, holds the FSM and sweep counter. It outputs sweep_we, sweep_addr and init_done.
- prf_multiport contains the array, ready bits, write priority and read/bypass muxes.

Test Plan:
- Reset, then idle with ADDR_W=6 → init_done low for exactly 63 cycles, then high. All 64 rd_ready reads = 1 and rd_data = 0.
- In RUN, write port0 addr 5 = 0xDEADBEEF → next cycle, any rd port at addr 5 returns 0xDEADBEEF, ready 1. A write to addr 0 with 0x1234 → read of addr 0 still returns 0.
- Same-cycle writes port0 addr 9 = 0x11 and port1 addr 9 = 0x22 → addr 9 reads 0x22.
- alloc addr 7 → rd_ready 0 next cycle. alloc 7 plus write 7 = 0x55 in the same cycle → ready stays 0, data 0x55. Write 7 alone → ready 1. alloc 7 plus flush → ready 1.
- With PRF_BYPASS_EN, read addr 12 in the cycle port1 writes 0xCAFE to 12 → same-cycle rd_data 0xCAFE, ready 1. Without the macro → old value in that cycle, 0xCAFE the next cycle.
- arst_n pulsed low at sweep cycle 20 → init_done stays 0 and the sweep restarts. Writes issued during INIT are ignored: after init, the targeted entry reads 0.
